// File: rtl/mem_bram_pipe.sv
// rtl/mem_bram_pipe.sv - pipelined Wishbone B4 block-RAM slave with fixed latency
module mem_bram_pipe #(
    parameter int    DW             = 32,
    parameter int    DEPTH          = 1024,
    parameter int    LATENCY        = 2,
    parameter string MEM_FILE       = "",
    parameter int    HARDWIRE_ZERO  = 0,
    parameter int    CLEAR_ON_RESET = 0
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [31:0]     i_wb_addr,
    input  logic [DW-1:0]   i_wb_data,
    input  logic [DW/8-1:0] i_wb_sel,
    output logic [DW-1:0]   o_wb_data,
    output logic            o_wb_ack,
    output logic            o_wb_err,
    output logic            o_wb_stall
);

    localparam int              NB       = DW / 8;
    localparam int              BSHIFT   = $clog2(NB);
    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0]     DEPTH_W  = 32'(DEPTH);
    localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;

    // Response pipeline; index 0 is the read-port register, LATENCY-1 drives the bus
    logic            vld_q [LATENCY];
    logic            vld_d [LATENCY];
    logic            err_q [LATENCY];
    logic            err_d [LATENCY];
    logic [DW-1:0]   dat_q [LATENCY];
    logic [DW-1:0]   dat_d [LATENCY];

    logic [DW-1:0]   mem [DEPTH];

    logic [31:0]     word_idx;
    logic [AW-1:0]   mem_idx;
    logic            oor;
    logic            hz_hit;
    logic            accept;
    logic [DW-1:0]   mem_rdata;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [DW-1:0]   mem_wdata;
    logic [NB-1:0]   mem_be;

    assign word_idx   = i_wb_addr >> BSHIFT;
    assign mem_idx    = word_idx[AW-1:0];
    // Any word index past the array, including stray upper address bits, is an error
    assign oor        = (word_idx >= DEPTH_W);
    assign hz_hit     = (HARDWIRE_ZERO != 0) && (word_idx == 32'd0);
    assign o_wb_stall = (state_q == S_CLEAR);
    assign accept     = i_wb_cyc & i_wb_stb & ~o_wb_stall;
    assign mem_rdata  = mem[mem_idx];

    // Next state: sweep every word once after reset, then serve the bus forever
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            S_CLEAR: begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == LAST_IDX) begin
                    state_d   = S_RUN;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // State and sweep counter registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= RESET_STATE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Write-port mux: the clear sweep owns the port while stalled, else accepted writes
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = mem_idx;
        mem_wdata = i_wb_data;
        mem_be    = i_wb_sel;
        if (state_q == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
            mem_be    = '1;
        end else if (accept && i_wb_we && !oor && !hz_hit) begin
            mem_we = 1'b1;
        end
    end

    // Byte-enabled array write; contents survive reset
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int k = 0; k < NB; k++) begin
                if (mem_be[k]) begin
                    mem[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
                end
            end
        end
    end

    // Pipeline advance; dropping cyc kills every in-flight response
    always_comb begin
        for (int i = 0; i < LATENCY; i++) begin
            vld_d[i] = 1'b0;
            err_d[i] = 1'b0;
            dat_d[i] = '0;
        end
        if (i_wb_cyc) begin
            vld_d[0] = accept;
            err_d[0] = accept & oor;
            dat_d[0] = (accept && !i_wb_we && !oor && !hz_hit) ? mem_rdata : '0;
            for (int i = 1; i < LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
                err_d[i] = err_q[i-1];
                dat_d[i] = dat_q[i-1];
            end
        end
    end

    // Pipeline registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                err_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i] <= vld_d[i];
                err_q[i] <= err_d[i];
                dat_q[i] <= dat_d[i];
            end
        end
    end

    // Responses are masked whenever the master is not holding cyc
    assign o_wb_ack  = i_wb_cyc & vld_q[LATENCY-1] & ~err_q[LATENCY-1];
    assign o_wb_err  = i_wb_cyc & vld_q[LATENCY-1] & err_q[LATENCY-1];
    assign o_wb_data = o_wb_ack ? dat_q[LATENCY-1] : '0;

endmodule

// File: tb/tb_mem_bram_pipe.sv
// tb/tb_mem_bram_pipe.sv - scoreboard bench for mem_bram_pipe, two configurations
module tb_mem_bram_pipe;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = '0;

    logic [31:0] dat_a, dat_b;
    logic        ack_a, err_a, stall_a;
    logic        ack_b, err_b, stall_b;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc_n = 0;
    int          b_left = 16;
    int          ack_a_cnt = 0;
    int          ack_b_cnt = 0;
    logic        cur_err = 1'b0;
    logic [31:0] cur_data = '0;
    logic [31:0] mem_b [16];
    resp_t       qa[$];
    resp_t       qb[$];

    // A: LATENCY 2, DEPTH 1024, word 0 hardwired to zero
    mem_bram_pipe #(
        .DW(32), .DEPTH(1024), .LATENCY(2), .MEM_FILE(""),
        .HARDWIRE_ZERO(1), .CLEAR_ON_RESET(0)
    ) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb),
        .i_wb_we(we), .i_wb_addr(adr), .i_wb_data(wdat), .i_wb_sel(sel),
        .o_wb_data(dat_a), .o_wb_ack(ack_a), .o_wb_err(err_a), .o_wb_stall(stall_a)
    );

    // B: LATENCY 3, DEPTH 16, clear sweep after reset
    mem_bram_pipe #(
        .DW(32), .DEPTH(16), .LATENCY(3), .MEM_FILE(""),
        .HARDWIRE_ZERO(0), .CLEAR_ON_RESET(1)
    ) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb),
        .i_wb_we(we), .i_wb_addr(adr), .i_wb_data(wdat), .i_wb_sel(sel),
        .o_wb_data(dat_b), .o_wb_ack(ack_b), .o_wb_err(err_b), .o_wb_stall(stall_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_resp(input string nm, input logic ack, input logic err,
                            input logic [31:0] dat, input bit have, input resp_t e);
        chk({nm, "_ack"}, 32'(ack), have ? 32'(!e.err) : 32'd0);
        chk({nm, "_err"}, 32'(err), have ? 32'(e.err) : 32'd0);
        chk({nm, "_data"}, dat, have ? e.data : 32'd0);
    endtask

    function automatic logic [31:0] dval(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic e_err, input logic [31:0] e_dat);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        cur_err = e_err; cur_data = e_dat;
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic idle(input int n);
        cyc = 1'b1; stb = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_b[i] = '0;
    end

    // Model of an asynchronous reset: everything in flight is gone, B restarts its sweep
    initial forever begin
        @(negedge rst_n);
        qa.delete();
        qb.delete();
        b_left = 16;
        for (int i = 0; i < 16; i++) mem_b[i] = '0;
    end

    // Accept-edge scoreboard push: A from the stimulus expectation, B from a reference memory
    initial forever begin
        @(posedge clk);
        if (rst_n) begin
            cyc_n++;
            if (cyc && stb) begin
                qa.push_back('{due: cyc_n + 1, err: cur_err, data: cur_data});
                if (b_left == 0) begin
                    if (adr >= 32'd64) begin
                        qb.push_back('{due: cyc_n + 2, err: 1'b1, data: 32'd0});
                    end else if (we) begin
                        for (int k = 0; k < 4; k++)
                            if (sel[k]) mem_b[adr[5:2]][8*k +: 8] = wdat[8*k +: 8];
                        qb.push_back('{due: cyc_n + 2, err: 1'b0, data: 32'd0});
                    end else begin
                        qb.push_back('{due: cyc_n + 2, err: 1'b0, data: mem_b[adr[5:2]]});
                    end
                end
            end
            if (b_left > 0) b_left--;
        end
    end

    // Per-cycle response and stall check, sampled mid-cycle
    initial forever begin
        resp_t ea, eb;
        bit    ha, hb;
        @(negedge clk);
        ha = 0; hb = 0;
        ea = '{due: 0, err: 1'b0, data: 32'd0};
        eb = '{due: 0, err: 1'b0, data: 32'd0};
        if (!rst_n || !cyc) begin
            qa.delete();
            qb.delete();
        end else begin
            if (qa.size() > 0 && qa[0].due == cyc_n) begin ha = 1; ea = qa.pop_front(); end
            if (qb.size() > 0 && qb[0].due == cyc_n) begin hb = 1; eb = qb.pop_front(); end
        end
        chk("stall_a", 32'(stall_a), 32'd0);
        chk("stall_b", 32'(stall_b), (!rst_n || b_left > 0) ? 32'd1 : 32'd0);
        chk_resp("a", ack_a, err_a, dat_a, ha, ea);
        chk_resp("b", ack_b, err_b, dat_b, hb, eb);
        if (ack_a) ack_a_cnt++;
        if (ack_b) ack_b_cnt++;
    end

    initial begin
        vec_t tbl [16];
        int   c0, c1, cnt;

        tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0000_0000};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 1'b0, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 32'h0000_0008, 32'h1122_3344, 4'hF, 1'b0, 32'h0000_0000};
        tbl[3]  = '{1'b1, 32'h0000_0008, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h0000_0000};
        tbl[4]  = '{1'b0, 32'h0000_0008, 32'h0000_0000, 4'h0, 1'b0, 32'h11BB_33DD};
        tbl[5]  = '{1'b1, 32'h0000_0000, 32'h0000_0005, 4'hF, 1'b0, 32'h0000_0000};
        tbl[6]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 1'b0, 32'h0000_0000};
        tbl[7]  = '{1'b0, 32'h0000_1000, 32'h0000_0000, 4'h0, 1'b1, 32'h0000_0000};
        tbl[8]  = '{1'b1, 32'h0000_1010, 32'h1234_5678, 4'hF, 1'b1, 32'h0000_0000};
        tbl[9]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 1'b0, 32'hDEAD_BEEF};
        tbl[10] = '{1'b1, 32'h0000_0FFC, 32'h0F0F_0F0F, 4'hF, 1'b0, 32'h0000_0000};
        tbl[11] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 4'h0, 1'b0, 32'h0F0F_0F0F};
        tbl[12] = '{1'b1, 32'h0000_0014, 32'h0102_0304, 4'hF, 1'b0, 32'h0000_0000};
        tbl[13] = '{1'b1, 32'h0000_0014, 32'hCAFE_F00D, 4'h0, 1'b0, 32'h0000_0000};
        tbl[14] = '{1'b0, 32'h0000_0014, 32'h0000_0000, 4'h0, 1'b0, 32'h0102_0304};
        tbl[15] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 1'b1, 32'h0000_0000};

        // Reset state
        #1 rst_n = 1'b0;
        #11;
        chk("rst_ack_a", 32'(ack_a), 32'd0);
        chk("rst_data_a", dat_a, 32'd0);
        chk("rst_stall_a", 32'(stall_a), 32'd0);
        chk("rst_stall_b", 32'(stall_b), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(20);

        // Table: single-word traffic, byte enables, hardwired zero, range errors
        for (int i = 0; i < 16; i++)
            drive(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].sel, tbl[i].exp_err, tbl[i].exp_data);
        idle(5);

        // Back-to-back: fill words 0..7 then read them with no gaps
        for (int i = 0; i < 8; i++) drive(1'b1, 32'(i * 4), dval(i), 4'hF, 1'b0, 32'd0);
        idle(4);
        c0 = ack_b_cnt;
        for (int i = 0; i < 8; i++)
            drive(1'b0, 32'(i * 4), 32'd0, 4'h0, 1'b0, (i == 0) ? 32'd0 : dval(i));
        idle(6);
        chk("b2b_ack_count_b", 32'(ack_b_cnt - c0), 32'd8);

        // Abort: three reads, cyc dropped for one cycle, then raised again
        c0 = ack_a_cnt; c1 = ack_b_cnt;
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h4, 32'd0, 4'h0, 1'b0, dval(1));
        cyc = 1'b0;
        @(posedge clk); #1;
        idle(6);
        chk("abort_acks_a", 32'(ack_a_cnt - c0), 32'd1);
        chk("abort_acks_b", 32'(ack_b_cnt - c1), 32'd0);

        // Asynchronous reset while A is presenting a response
        drive(1'b0, 32'h14, 32'd0, 4'h0, 1'b0, dval(5));
        drive(1'b0, 32'h14, 32'd0, 4'h0, 1'b0, dval(5));
        chk("pre_rst_ack_a", 32'(ack_a), 32'd1);
        chk("pre_rst_data_a", dat_a, dval(5));
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ack_a", 32'(ack_a), 32'd0);
        chk("mid_rst_data_a", dat_a, 32'd0);
        chk("mid_rst_ack_b", 32'(ack_b), 32'd0);
        chk("mid_rst_err_b", 32'(err_b), 32'd0);
        #1 rst_n = 1'b1;

        // B must stall for exactly DEPTH cycles while sweeping
        cnt = 0;
        @(negedge clk);
        while (stall_b === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("clear_cycles_b", 32'(cnt), 32'd16);
        @(posedge clk); #1;
        drive(1'b0, 32'h14, 32'd0, 4'h0, 1'b0, dval(5));
        drive(1'b0, 32'h1C, 32'd0, 4'h0, 1'b0, dval(7));
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
